// File: rtl/motor_pwm_ramp.sv
// Dual-channel H-bridge PWM with soft-start duty ramping, zero-duty direction reversal and a fault FSM.
// Optional macro AUTO_RETRY_EN adds a COOL state that re-arms the bridges after a cooldown.
module motor_pwm_ramp #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 16,
  parameter int RAMP_DIV     = 65536,
  parameter int RETRY_CYCLES = 100000000
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic [PWM_BITS-1:0] DUTY_A,
  input  logic [PWM_BITS-1:0] DUTY_B,
  input  logic                DIR_A,
  input  logic                DIR_B,
  input  logic                ENA,
  input  logic                ENB,
  input  logic                OVERCURRENT,
  output logic                PWM_A,
  output logic                PWM_B,
  output logic                IN1,
  output logic                IN2,
  output logic                IN3,
  output logic                IN4,
  output logic                FAULT
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

`ifdef AUTO_RETRY_EN
  localparam int COOL_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  typedef enum logic [1:0] {S_RUN, S_FAULT, S_COOL} state_t;
`else
  typedef enum logic {S_RUN, S_FAULT} state_t;
`endif

  state_t r_state, w_state_nxt;

  logic [PRE_W-1:0]    r_pre_cnt;
  logic [RAMP_W-1:0]   r_ramp_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_pre_wrap, w_tick, w_fault_in, w_run_ok;

  logic [1:0][PWM_BITS-1:0] r_duty, w_duty_in, w_tgt;
  logic [1:0]               r_dir_q, w_dir_in, r_pwm;
  logic [1:0][1:0]          r_in;

  assign w_duty_in  = {DUTY_B, DUTY_A};
  assign w_dir_in   = {DIR_B, DIR_A};
  assign w_fault_in = OVERCURRENT | ~ENA | ~ENB;
  // Gate on the live fault inputs so the pins drop on the very edge the fault is sampled.
  assign w_run_ok   = (r_state == S_RUN) && !w_fault_in;
  assign w_pre_wrap = (r_pre_cnt == PRE_W'(PRESCALE - 1));
  assign w_tick     = (r_ramp_cnt == RAMP_W'(RAMP_DIV - 1));

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_ramp_cnt <= '0;
    end else begin
      r_pre_cnt  <= w_pre_wrap ? '0 : r_pre_cnt + 1'b1;
      r_ramp_cnt <= w_tick ? '0 : r_ramp_cnt + 1'b1;
      if (w_pre_wrap) r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // A pending reversal targets zero; the direction only latches once the channel is stopped.
  always_comb begin
    w_tgt = '0;
    for (int ch = 0; ch < 2; ch++)
      w_tgt[ch] = (w_dir_in[ch] != r_dir_q[ch]) ? '0 : w_duty_in[ch];
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_duty  <= '0;
      r_dir_q <= '1;
    end else if (!w_run_ok) begin
      r_duty <= '0;
    end else if (w_tick) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (r_duty[ch] == '0) r_dir_q[ch] <= w_dir_in[ch];
        if (r_duty[ch] < w_tgt[ch])      r_duty[ch] <= r_duty[ch] + 1'b1;
        else if (r_duty[ch] > w_tgt[ch]) r_duty[ch] <= r_duty[ch] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_pwm <= '0;
      r_in  <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        r_pwm[ch] <= w_run_ok && (r_pwm_cnt < r_duty[ch]);
        if (!w_run_ok || r_duty[ch] == '0) r_in[ch] <= 2'b00;
        else                               r_in[ch] <= r_dir_q[ch] ? 2'b10 : 2'b01;
      end
    end
  end

`ifdef AUTO_RETRY_EN
  logic [COOL_W-1:0] r_cool_cnt;
  logic              w_cool_done;

  assign w_cool_done = (r_cool_cnt == COOL_W'(RETRY_CYCLES - 1));

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST)                                    r_cool_cnt <= '0;
    else if (r_state != S_COOL || w_cool_done)  r_cool_cnt <= '0;
    else                                        r_cool_cnt <= r_cool_cnt + 1'b1;
  end
`endif

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_fault_in) w_state_nxt = S_FAULT;
`ifdef AUTO_RETRY_EN
      S_FAULT: w_state_nxt = S_COOL;
      S_COOL:  if (w_cool_done && !w_fault_in) w_state_nxt = S_RUN;
`else
      S_FAULT: w_state_nxt = S_FAULT;
`endif
      default: w_state_nxt = S_FAULT;
    endcase
  end

  assign PWM_A = r_pwm[0];
  assign PWM_B = r_pwm[1];
  assign IN1   = r_in[0][1];
  assign IN2   = r_in[0][0];
  assign IN3   = r_in[1][1];
  assign IN4   = r_in[1][0];
  assign FAULT = (r_state != S_RUN);

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Directed bench for motor_pwm_ramp: ramping, reversal, fault handling and async reset.
// Run with AUTO_RETRY_EN defined to cover the cooldown/re-arm path.
module tb_motor_pwm_ramp;
  localparam int PWM_BITS = 4;

  logic                CLK100MHZ = 1'b0;
  logic                RST = 1'b1;
  logic [PWM_BITS-1:0] DUTY_A = '0, DUTY_B = '0;
  logic                DIR_A = 1'b1, DIR_B = 1'b1;
  logic                ENA = 1'b1, ENB = 1'b1, OVERCURRENT = 1'b0;
  logic                PWM_A, PWM_B, IN1, IN2, IN3, IN4, FAULT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  motor_pwm_ramp #(.PWM_BITS(PWM_BITS), .PRESCALE(1), .RAMP_DIV(4), .RETRY_CYCLES(20)) dut (
    .CLK100MHZ(CLK100MHZ), .RST(RST),
    .DUTY_A(DUTY_A), .DUTY_B(DUTY_B), .DIR_A(DIR_A), .DIR_B(DIR_B),
    .ENA(ENA), .ENB(ENB), .OVERCURRENT(OVERCURRENT),
    .PWM_A(PWM_A), .PWM_B(PWM_B), .IN1(IN1), .IN2(IN2), .IN3(IN3), .IN4(IN4),
    .FAULT(FAULT)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  // High-sample count of each PWM over n consecutive clocks.
  task automatic win(input int n, output int ha, output int hb);
    ha = 0; hb = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      ha += int'(PWM_A);
      hb += int'(PWM_B);
    end
  endtask

  int ha, hb, ph, bad, seen;
  logic [1:0] ina;

  initial begin
    // Reset state
    DUTY_A = 4'd8; DUTY_B = 4'd3; DIR_B = 1'b0;
    step(2);
    chk("rst_pwm", {PWM_A, PWM_B}, 0);
    chk("rst_in", {IN1, IN2, IN3, IN4}, 0);
    chk("rst_fault", FAULT, 0);
    RST = 1'b0;

    // 1: ramp to 8 in 32 clocks; B reverses from reset-forward then climbs to 3
    step(3);
    chk("t1_in_idle_early", {IN1, IN2}, 0);
    step(30);
    win(16, ha, hb);
    chk("t1_pwm_a_8of16", ha, 8);
    chk("t1_pwm_b_3of16", hb, 3);
    chk("t1_in_a_fwd", {IN1, IN2}, 2);
    chk("t1_in_b_rev", {IN3, IN4}, 1);

    // 2: max duty low 1 of 16; then ramp down to 0 within 60 clocks
    DUTY_A = 4'd15;
    step(40);
    win(16, ha, hb);
    chk("t2_pwm_a_15of16", ha, 15);
    DUTY_A = 4'd0;
    step(62);
    win(32, ha, hb);
    chk("t2_pwm_a_off", ha, 0);
    chk("t2_in_a_idle", {IN1, IN2}, 0);

    // 3: reversal at duty 8: 10 -> 00 -> 01, PWM never high while idle
    DUTY_A = 4'd8;
    step(40);
    chk("t3_in_a_fwd", {IN1, IN2}, 2);
    DIR_A = 1'b0;
    ph = 0; bad = 0;
    for (int i = 0; i < 200 && ph < 2; i++) begin
      step(1);
      ina = {IN1, IN2};
      if (ina == 2'b00 && PWM_A) bad++;
      if (ina == 2'b11) bad++;
      if (ph == 0 && ina == 2'b00) ph = 1;
      else if (ph == 0 && ina == 2'b01) bad++;
      else if (ph == 1 && ina == 2'b01) ph = 2;
      else if (ph == 1 && ina == 2'b10) bad++;
    end
    chk("t3_rev_sequence", ph, 2);
    chk("t3_no_pwm_when_idle", bad, 0);
    step(40);
    win(16, ha, hb);
    chk("t3_pwm_a_8of16", ha, 8);
    chk("t3_in_a_rev", {IN1, IN2}, 1);

    // 4: one-clock ENB drop shuts everything within 2 clocks
    ENB = 1'b0;
    step(1);
    ENB = 1'b1;
    step(1);
    chk("t4_pwm_off", {PWM_A, PWM_B}, 0);
    chk("t4_in_off", {IN1, IN2, IN3, IN4}, 0);
    chk("t4_fault", FAULT, 1);
`ifndef AUTO_RETRY_EN
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (!FAULT || PWM_A || PWM_B || IN1 || IN2 || IN3 || IN4) bad++;
    end
    chk("t4_fault_terminal", bad, 0);
`else
    // 5: cooldown re-arm; held OVERCURRENT keeps FAULT across 3 cooldowns
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step(1);
      if (!FAULT) seen = 1;
    end
    chk("t5_rearm_after_blip", seen, 1);
    OVERCURRENT = 1'b1;
    step(2);
    chk("t5_fault_oc", FAULT, 1);
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      step(1);
      if (!FAULT || PWM_A || PWM_B) bad++;
    end
    chk("t5_fault_held", bad, 0);
    OVERCURRENT = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (!FAULT) seen = 1;
    end
    chk("t5_rearm", seen, 1);
    chk("t5_ramp_from_zero", {IN1, IN2, IN3, IN4}, 0);
    step(40);
    win(16, ha, hb);
    chk("t5_pwm_a_8of16", ha, 8);
`endif

    // 6: async reset mid-ramp (duty 5) clears outputs before the next edge
    RST = 1'b1;
    DIR_A = 1'b1;
    #2;
    RST = 1'b0;
    step(22);
    chk("t6_in_a_fwd_prereset", {IN1, IN2}, 2);
    #1;
    RST = 1'b1;
    #1;
    chk("t6_async_pwm", {PWM_A, PWM_B}, 0);
    chk("t6_async_in", {IN1, IN2, IN3, IN4}, 0);
    RST = 1'b0;
    step(3);
    chk("t6_duty_cleared", {IN1, IN2}, 0);
    step(40);
    win(16, ha, hb);
    chk("t6_pwm_a_8of16", ha, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
